// File: rtl/mem_pkg.sv
// Shared constants and helpers for banked_memory: read-latency bounds, byte-lane merge and window decode.
// Pure combinational functions; no latency, no backpressure.
package mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int MAX_W      = 256;
  localparam int MAX_B      = MAX_W / 8;

  typedef struct packed {
    logic        hit;
    logic [31:0] offs;
  } dec_t;

  // 32-bit wrapping subtraction makes addresses below the base land far above the span.
  function automatic dec_t decode(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [32:0] span);
    dec_t d;
    d.offs = addr - base;
    d.hit  = ({1'b0, d.offs} < span);
    return d;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] mask);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_B; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_pipe.sv
// Valid+data delay line, DEPTH cycles; each data stage loads only when a load flag travels with it.
// The last data stage therefore holds its value until the next load arrives; never stalls.
module mem_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic             in_ld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic             vld_c [DEPTH+1];
  logic             ld_c  [DEPTH];
  logic [WIDTH-1:0] dat_c [DEPTH+1];

  assign vld_c[0] = in_vld;
  assign ld_c[0]  = in_ld;
  assign dat_c[0] = in_dat;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_c[s+1] <= 1'b0;
        dat_c[s+1] <= '0;
      end else begin
        vld_c[s+1] <= vld_c[s];
        if (ld_c[s]) dat_c[s+1] <= dat_c[s];
      end
    end

    // The final stage needs no load flag of its own: it is the holding register.
    if (s < DEPTH - 1) begin : g_ld
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_c[s+1] <= 1'b0;
        else        ld_c[s+1] <= ld_c[s];
      end
    end
  end

  assign out_vld = vld_c[DEPTH];
  assign out_dat = dat_c[DEPTH];

endmodule

// File: rtl/banked_memory.sv
// Windowed word memory slave: RD_LAT-cycle pipelined reads, one done pulse per accepted request, no stalls.
// BANKED_MEMORY_WRITE_FIRST_EN selects write-first data for a combined read+write; default is read-first.
module banked_memory
  import mem_pkg::*;
#(
  parameter int          SIZE      = 256,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1,
  parameter string       INIT_H    = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_wstrobe,
  input  logic                mem_rstrobe,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                active
);

  localparam int          BYTES = DATA_W / 8;
  localparam int          LG    = $clog2(BYTES);
  localparam int          AW    = $clog2(SIZE);
  localparam logic [32:0] SPAN  = 33'(SIZE) * 33'(BYTES);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || DATA_W > MAX_W || SIZE < 2) begin : g_bad_cfg
    $error("banked_memory: unsupported parameter combination");
  end

  logic [DATA_W-1:0] mem [SIZE];

  dec_t              dec;
  logic [AW-1:0]     idx;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;

  assign dec    = decode(mem_addr, BASE_ADDR, SPAN);
  assign active = dec.hit;
  assign idx    = AW'(dec.offs >> LG);
  assign acc    = (mem_wstrobe | mem_rstrobe) & active;
  assign wr_acc = mem_wstrobe & active;
  assign rd_acc = mem_rstrobe & active;

  assign old_w  = mem[idx];
  assign merged = DATA_W'(byte_merge(MAX_W'(old_w), MAX_W'(mem_wdata), MAX_B'(mem_wmask)));

`ifdef BANKED_MEMORY_WRITE_FIRST_EN
  assign rd_word = mem_wstrobe ? merged : old_w;
`else
  assign rd_word = old_w;
`endif

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= merged;
  end

  mem_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (DATA_W)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (acc),
    .in_ld   (rd_acc),
    .in_dat  (rd_word),
    .out_vld (mem_done),
    .out_dat (mem_rdata)
  );

endmodule

// File: tb/tb_banked_memory.sv
// Randomized + directed bench for banked_memory against a queue-based reference model.
module tb_banked_memory;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SIZE = 256;
  localparam int          LAT  = 3;
`ifdef BANKED_MEMORY_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_wstrobe = 1'b0;
  logic        mem_rstrobe = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        active;

  banked_memory #(
    .SIZE      (SIZE),
    .DATA_W    (32),
    .BASE_ADDR (BASE),
    .RD_LAT    (LAT),
    .INIT_H    ("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_wstrobe (mem_wstrobe),
    .mem_rstrobe (mem_rstrobe),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .active      (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [SIZE];
  exp_t        q[$];
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Called at a falling edge: drive one request, model it, then observe after the next rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input bit ws, input bit rs);
    logic [31:0] offs, old_w, new_w;
    bit          act, exp_done;
    int          idx;
    exp_t        e;
    mem_addr    = a;
    mem_wdata   = wd;
    mem_wmask   = wm;
    mem_wstrobe = ws;
    mem_rstrobe = rs;
    offs = a - BASE;
    act  = (offs < 32'(SIZE * 4));
    #1 chk("active", 32'(active), 32'(act));
    if (act && (ws || rs)) begin
      idx   = int'(offs / 4);
      old_w = ref_mem[idx];
      new_w = old_w;
      for (int b = 0; b < 4; b++) if (wm[b]) new_w[8*b +: 8] = wd[8*b +: 8];
      e.due = cyc + LAT;
      e.rd  = rs;
      e.dat = (ws && WF) ? new_w : old_w;
      if (ws) ref_mem[idx] = new_w;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_done = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_done = 1'b1;
      if (e.rd) exp_rdata = e.dat;
    end
    chk("done", 32'(mem_done), 32'(exp_done));
    chk("rdata", mem_rdata, exp_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  wm;
    int          sel;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 32'(mem_done), 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    rst_n = 1'b1;

    // Seed a small working set plus the last word of the window.
    for (int w = 0; w < 16; w++) step(BASE + 32'(w * 4), $urandom, 4'hF, 1'b1, 1'b0);
    step(BASE + 32'h3FC, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
    step(BASE + 32'h3FC, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("last_word", mem_rdata, 32'hCAFE_F00D);

    step(32'h1004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    step(32'h1004, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("rd_deadbeef", mem_rdata, 32'hDEAD_BEEF);

    step(32'h0FFC, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h1400, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h1400, 32'h5555_5555, 4'hF, 1'b1, 1'b0);
    idle(LAT);
    chk("oow_rdata", mem_rdata, 32'hDEAD_BEEF);

    step(32'h1004, 32'h1234_5678, 4'h0, 1'b1, 1'b0);
    step(32'h1006, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("mask0_rdata", mem_rdata, 32'hDEAD_BEEF);

    step(32'h1000, 32'd1, 4'hF, 1'b1, 1'b0);
    step(32'h1004, 32'd2, 4'hF, 1'b1, 1'b0);
    step(32'h1008, 32'd3, 4'hF, 1'b1, 1'b0);
    step(32'h1000, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h1004, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h1008, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("b2b_last", mem_rdata, 32'd3);

    step(32'h1014, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
    step(32'h1014, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b1);
    idle(LAT);
    chk("combined_rdata", mem_rdata, WF ? 32'h11BB_33DD : 32'h1122_3344);
    step(32'h1014, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("combined_array", mem_rdata, 32'h11BB_33DD);

    // Asynchronous reset with a read in flight.
    step(32'h1008, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", 32'(mem_done), 32'h0);
    chk("arst_rdata", mem_rdata, 32'h0);
    q.delete();
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 2);
    step(32'h1004, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(LAT);
    chk("post_reset_word", mem_rdata, 32'd2);

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      a = $urandom_range(0, 32'h0FFF);
      else if (sel == 1) a = 32'h1400 + $urandom_range(0, 32'h0FFF);
      else               a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      wm = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      step(a, $urandom, wm, 1'($urandom), 1'($urandom));
    end
    idle(LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
